// File: rtl/blackjack_table_ctrl.sv
// ---------------------------------------------------------------------------
// blackjack_table_ctrl
//
// Multi-seat blackjack round controller. Deals NUM_SEATS player hands plus a
// dealer hand from an external deck through a req/valid handshake. It then runs
// each seat's turn in order, lets the dealer draw to its threshold, and settles
// every seat against the dealer.
//
// Optional feature macro: DEALER_HIT_SOFT17_EN
//   defined   -> dealer also draws on a soft 17 (ace counted as 11)
//   undefined -> dealer stands on every effective sum >= DEALER_STAND
//
// Ports
//   i_clk          clock, all logic on rising edge
//   i_reset        synchronous active-high reset
//   i_start        begin a round (only honoured in IDLE)
//   i_hit          active seat requests a card
//   i_stand        active seat stands
//   o_card_req     registered request for the next deck card
//   i_card_valid   deck card valid this cycle
//   i_card_rank    1=A, 2..10, 11..13=J/Q/K (0/14/15 are ignored)
//   o_active_seat  seat whose turn it is
//   o_seat_sum     effective sums, seat 0 in the LSBs
//   o_dealer_sum   dealer effective sum
//   o_result       2 bits per seat: 00 none, 01 lose, 10 tie, 11 win
//   o_state        FSM state code
//   o_round_done   one-cycle pulse on entering DONE
// ---------------------------------------------------------------------------
module blackjack_table_ctrl #(
    parameter int NUM_SEATS    = 2,
    parameter int MAX_CARDS    = 5,
    parameter int DEALER_STAND = 17,
    parameter int SUM_W        = 6
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic                       i_hit,
    input  logic                       i_stand,
    output logic                       o_card_req,
    input  logic                       i_card_valid,
    input  logic [3:0]                 i_card_rank,
    output logic [1:0]                 o_active_seat,
    output logic [NUM_SEATS*SUM_W-1:0] o_seat_sum,
    output logic [SUM_W-1:0]           o_dealer_sum,
    output logic [NUM_SEATS*2-1:0]     o_result,
    output logic [2:0]                 o_state,
    output logic                       o_round_done
);

    localparam int HANDS = NUM_SEATS + 1;
    localparam int CNT_W = $clog2(MAX_CARDS + 1);

    localparam logic [SUM_W-1:0] SUM_TEN   = SUM_W'(10);
    localparam logic [SUM_W-1:0] SUM_21    = SUM_W'(21);
    localparam logic [SUM_W-1:0] SUM_STAND = SUM_W'(DEALER_STAND);
    localparam logic [SUM_W-1:0] SUM_MAX   = {SUM_W{1'b1}};
    localparam logic [SUM_W:0]   SUM_TEN_X = (SUM_W+1)'(10);
    localparam logic [SUM_W:0]   SUM_21_X  = (SUM_W+1)'(21);
    localparam logic [SUM_W:0]   SUM_MAX_X = {1'b0, {SUM_W{1'b1}}};
`ifdef DEALER_HIT_SOFT17_EN
    localparam logic [SUM_W-1:0] SUM_17    = SUM_W'(17);
`endif

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CARDS);

    localparam logic [2:0] DEALER_IDX = 3'(NUM_SEATS);
    localparam logic [1:0] LAST_SEAT  = 2'(NUM_SEATS - 1);

    localparam logic [1:0] RES_LOSE = 2'b01;
    localparam logic [1:0] RES_TIE  = 2'b10;
    localparam logic [1:0] RES_WIN  = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEAL      = 3'd1,
        CHK_DBJ   = 3'd2,
        PLAYER    = 3'd3,
        NEXT_SEAT = 3'd4,
        DEALER    = 3'd5,
        SETTLE    = 3'd6,
        DONE      = 3'd7
    } state_t;

    state_t                 state;
    logic                   cardReq;
    logic [1:0]             activeSeat;
    logic [2:0]             dealSeat;
    logic                   dealPass;
    logic                   roundDone;
    logic [NUM_SEATS*2-1:0] result;

    // Hand storage: indices 0..NUM_SEATS-1 are seats, index NUM_SEATS is the dealer
    logic [SUM_W-1:0] hardSum [HANDS];
    logic             hasAce  [HANDS];
    logic [CNT_W-1:0] cardCnt [HANDS];

    logic [SUM_W-1:0] effSum    [HANDS];
    logic             softAce   [HANDS];
    logic             isBust    [HANDS];
    logic             isBj      [HANDS];
    logic             isCharlie [HANDS];

    logic                   rankOk;
    logic                   cardTake;
    logic [3:0]             cardVal;
    logic [2:0]             targetHand;
    logic [SUM_W-1:0]       targetHard;
    logic [SUM_W:0]         addWide;
    logic [SUM_W-1:0]       newHard;
    logic [SUM_W-1:0]       actEff;
    logic [CNT_W-1:0]       actCnt;
    logic                   allBust;
    logic                   dealerDraw;
    logic [NUM_SEATS*2-1:0] settleResult;

    // Per-hand scoring. An ace counts as 11 only while that keeps the hand at
    // 21 or below. Since that needs hard <= 11, the narrow add cannot overflow.
    always_comb begin
        for (int h = 0; h < HANDS; h++) begin
            softAce[h]   = hasAce[h] && (({1'b0, hardSum[h]} + SUM_TEN_X) <= SUM_21_X);
            effSum[h]    = softAce[h] ? (hardSum[h] + SUM_TEN) : hardSum[h];
            isBust[h]    = effSum[h] > SUM_21;
            isBj[h]      = (cardCnt[h] == CNT_TWO) && (effSum[h] == SUM_21);
            isCharlie[h] = (cardCnt[h] == CNT_MAX) && !isBust[h];
        end
    end

    // Card intake. Only ranks 1..13 complete the handshake. Junk ranks leave the
    // request standing so the deck can present another card. The hard sum
    // saturates instead of wrapping.
    always_comb begin
        rankOk   = (i_card_rank != 4'd0) && (i_card_rank <= 4'd13);
        cardTake = cardReq && i_card_valid && rankOk;
        cardVal  = (i_card_rank > 4'd10) ? 4'd10 : i_card_rank;

        case (state)
            DEAL:    targetHand = dealSeat;
            PLAYER:  targetHand = {1'b0, activeSeat};
            default: targetHand = DEALER_IDX;
        endcase

        targetHard = '0;
        for (int h = 0; h < HANDS; h++) begin
            if (targetHand == 3'(h)) begin
                targetHard = hardSum[h];
            end
        end

        addWide = {1'b0, targetHard} + (SUM_W+1)'(cardVal);
        newHard = (addWide > SUM_MAX_X) ? SUM_MAX : addWide[SUM_W-1:0];
    end

    // Active seat view and the "everyone busted" shortcut past the dealer
    always_comb begin
        actEff  = '0;
        actCnt  = '0;
        allBust = 1'b1;
        for (int s = 0; s < NUM_SEATS; s++) begin
            if (activeSeat == 2'(s)) begin
                actEff = effSum[s];
                actCnt = cardCnt[s];
            end
            allBust = allBust && isBust[s];
        end
    end

    // Dealer keeps drawing while under the stand threshold and short of a
    // charlie. The optional soft-17 rule adds one more draw case.
    always_comb begin
        dealerDraw = (cardCnt[NUM_SEATS] < CNT_MAX) && (effSum[NUM_SEATS] < SUM_STAND);
`ifdef DEALER_HIT_SOFT17_EN
        if ((cardCnt[NUM_SEATS] < CNT_MAX) && softAce[NUM_SEATS] &&
            (effSum[NUM_SEATS] == SUM_17)) begin
            dealerDraw = 1'b1;
        end
`endif
    end

    // Settlement priority for each seat. The first rule that matches decides.
    always_comb begin
        settleResult = '0;
        for (int s = 0; s < NUM_SEATS; s++) begin
            if (isBj[NUM_SEATS])
                settleResult[2*s +: 2] = isBj[s] ? RES_TIE : RES_LOSE;
            else if (isBust[s])
                settleResult[2*s +: 2] = RES_LOSE;
            else if (isBj[s])
                settleResult[2*s +: 2] = RES_WIN;
            else if (isBust[NUM_SEATS])
                settleResult[2*s +: 2] = RES_WIN;
            else if (isCharlie[s])
                settleResult[2*s +: 2] = RES_WIN;
            else if (isCharlie[NUM_SEATS])
                settleResult[2*s +: 2] = RES_LOSE;
            else if (effSum[s] > effSum[NUM_SEATS])
                settleResult[2*s +: 2] = RES_WIN;
            else if (effSum[s] == effSum[NUM_SEATS])
                settleResult[2*s +: 2] = RES_TIE;
            else
                settleResult[2*s +: 2] = RES_LOSE;
        end
    end

    // Round FSM. A taken card lands in whichever hand the current state
    // targets, and the request always drops for a cycle after each take.
    // Reset has priority and discards any card presented on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            cardReq    <= 1'b0;
            activeSeat <= '0;
            dealSeat   <= '0;
            dealPass   <= 1'b0;
            roundDone  <= 1'b0;
            result     <= '0;
            for (int h = 0; h < HANDS; h++) begin
                hardSum[h] <= '0;
                hasAce[h]  <= 1'b0;
                cardCnt[h] <= '0;
            end
        end else begin
            roundDone <= 1'b0;

            if (cardTake) begin
                cardReq <= 1'b0;
                for (int h = 0; h < HANDS; h++) begin
                    if (targetHand == 3'(h)) begin
                        hardSum[h] <= newHard;
                        hasAce[h]  <= hasAce[h] || (i_card_rank == 4'd1);
                        cardCnt[h] <= cardCnt[h] + CNT_ONE;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        for (int h = 0; h < HANDS; h++) begin
                            hardSum[h] <= '0;
                            hasAce[h]  <= 1'b0;
                            cardCnt[h] <= '0;
                        end
                        result     <= '0;
                        dealSeat   <= '0;
                        dealPass   <= 1'b0;
                        activeSeat <= '0;
                        cardReq    <= 1'b1;
                        state      <= DEAL;
                    end
                end

                DEAL: begin
                    if (cardTake) begin
                        if (dealSeat == DEALER_IDX) begin
                            dealSeat <= '0;
                            if (dealPass)
                                state <= CHK_DBJ;
                            else
                                dealPass <= 1'b1;
                        end else begin
                            dealSeat <= dealSeat + 3'd1;
                        end
                    end else if (!cardReq) begin
                        cardReq <= 1'b1;
                    end
                end

                CHK_DBJ: begin
                    activeSeat <= '0;
                    state      <= isBj[NUM_SEATS] ? SETTLE : PLAYER;
                end

                PLAYER: begin
                    if (!cardReq) begin
                        if ((actEff >= SUM_21) || (actCnt >= CNT_MAX))
                            state <= NEXT_SEAT;
                        else if (i_stand)
                            state <= NEXT_SEAT;
                        else if (i_hit)
                            cardReq <= 1'b1;
                    end
                end

                NEXT_SEAT: begin
                    if (activeSeat == LAST_SEAT) begin
                        state <= allBust ? SETTLE : DEALER;
                    end else begin
                        activeSeat <= activeSeat + 2'd1;
                        state      <= PLAYER;
                    end
                end

                DEALER: begin
                    if (!cardReq) begin
                        if (dealerDraw)
                            cardReq <= 1'b1;
                        else
                            state <= SETTLE;
                    end
                end

                SETTLE: begin
                    result    <= settleResult;
                    roundDone <= 1'b1;
                    state     <= DONE;
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output mapping, seat 0 in the low bits
    always_comb begin
        o_seat_sum = '0;
        for (int s = 0; s < NUM_SEATS; s++) begin
            o_seat_sum[s*SUM_W +: SUM_W] = effSum[s];
        end
    end

    assign o_dealer_sum  = effSum[NUM_SEATS];
    assign o_card_req    = cardReq;
    assign o_active_seat = activeSeat;
    assign o_result      = result;
    assign o_state       = state;
    assign o_round_done  = roundDone;

endmodule

// File: tb/tb_blackjack_table_ctrl.sv
// ---------------------------------------------------------------------------
// tb_blackjack_table_ctrl
//
// Directed bench for blackjack_table_ctrl with NUM_SEATS=2. Each round is a
// hand-built deck sequence with hand-computed sums and results. The soft-17
// round follows DEALER_HIT_SOFT17_EN so it matches the build of the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_blackjack_table_ctrl;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DEAL      = 3'd1;
    localparam logic [2:0] S_CHK_DBJ   = 3'd2;
    localparam logic [2:0] S_PLAYER    = 3'd3;
    localparam logic [2:0] S_NEXT_SEAT = 3'd4;
    localparam logic [2:0] S_DEALER    = 3'd5;
    localparam logic [2:0] S_SETTLE    = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    logic        clk;
    logic        reset;
    logic        start;
    logic        hit;
    logic        stand;
    logic        cardReq;
    logic        cardValid;
    logic [3:0]  cardRank;
    logic [1:0]  activeSeat;
    logic [11:0] seatSum;
    logic [5:0]  dealerSum;
    logic [3:0]  result;
    logic [2:0]  state;
    logic        roundDone;

    int checks   = 0;
    int failures = 0;

    blackjack_table_ctrl #(
        .NUM_SEATS    (2),
        .MAX_CARDS    (5),
        .DEALER_STAND (17),
        .SUM_W        (6)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_hit         (hit),
        .i_stand       (stand),
        .o_card_req    (cardReq),
        .i_card_valid  (cardValid),
        .i_card_rank   (cardRank),
        .o_active_seat (activeSeat),
        .o_seat_sum    (seatSum),
        .o_dealer_sum  (dealerSum),
        .o_result      (result),
        .o_state       (state),
        .o_round_done  (roundDone)
    );

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just past the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counted, and reported with its tag on failure
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Pulse the player/start controls for exactly one cycle
    task automatic applyStimulus(input logic doStart, input logic doHit, input logic doStand);
        start = doStart;
        hit   = doHit;
        stand = doStand;
        step();
        start = 1'b0;
        hit   = 1'b0;
        stand = 1'b0;
    endtask

    // Wait (bounded) for a card request, then present one card for one cycle
    task automatic feedCard(input logic [3:0] rank);
        int n;
        n = 0;
        while (cardReq !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        checkOutput("cardReqWait", {31'd0, cardReq}, 32'd1);
        cardValid = 1'b1;
        cardRank  = rank;
        step();
        cardValid = 1'b0;
        cardRank  = 4'd0;
    endtask

    // Bounded wait for a given FSM state
    task automatic waitState(input logic [2:0] target, input string tag);
        int n;
        n = 0;
        while (state !== target && n < 100) begin
            step();
            n++;
        end
        checkOutput(tag, {29'd0, state}, {29'd0, target});
    endtask

    // Bounded wait for a seat's turn
    task automatic waitSeat(input logic [1:0] seat, input string tag);
        int n;
        n = 0;
        while (!(state === S_PLAYER && activeSeat === seat) && n < 100) begin
            step();
            n++;
        end
        checkOutput(tag, {27'd0, state, activeSeat}, {27'd0, S_PLAYER, seat});
    endtask

    // Deal six cards in order s0, s1, D, s0, s1, D
    task automatic dealSix(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2,
                           input logic [3:0] c3, input logic [3:0] c4, input logic [3:0] c5);
        feedCard(c0);
        feedCard(c1);
        feedCard(c2);
        feedCard(c3);
        feedCard(c4);
        feedCard(c5);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        start     = 1'b0;
        hit       = 1'b0;
        stand     = 1'b0;
        cardValid = 1'b0;
        cardRank  = 4'd0;

        // ---- reset state ----
        step();
        step();
        reset = 1'b0;
        checkOutput("rstState",  {29'd0, state}, 32'd0);
        checkOutput("rstReq",    {31'd0, cardReq}, 32'd0);
        checkOutput("rstSeat",   {30'd0, activeSeat}, 32'd0);
        checkOutput("rstSums",   {20'd0, seatSum}, 32'd0);
        checkOutput("rstDealer", {26'd0, dealerSum}, 32'd0);
        checkOutput("rstResult", {28'd0, result}, 32'd0);
        checkOutput("rstDone",   {31'd0, roundDone}, 32'd0);

        // ---- round 1: dealer blackjack, both seats lose ----
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("r1Deal", {29'd0, state}, {29'd0, S_DEAL});
        checkOutput("r1Req",  {31'd0, cardReq}, 32'd1);
        dealSix(4'd10, 4'd9, 4'd1, 4'd7, 4'd7, 4'd13);
        checkOutput("r1ChkDbj", {29'd0, state}, {29'd0, S_CHK_DBJ});
        checkOutput("r1Sums",   {20'd0, seatSum}, 32'd1041);   // s1=16, s0=17
        checkOutput("r1Dealer", {26'd0, dealerSum}, 32'd21);
        step();
        checkOutput("r1Settle", {29'd0, state}, {29'd0, S_SETTLE});
        step();
        checkOutput("r1DoneSt",  {29'd0, state}, {29'd0, S_DONE});
        checkOutput("r1Result",  {28'd0, result}, 32'b0101);
        checkOutput("r1DonePls", {31'd0, roundDone}, 32'd1);
        step();
        checkOutput("r1Idle",    {29'd0, state}, {29'd0, S_IDLE});
        checkOutput("r1DoneLow", {31'd0, roundDone}, 32'd0);
        checkOutput("r1Held",    {28'd0, result}, 32'b0101);

        // ---- round 2: s0 blackjack auto-advance, dealer busts ----
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("r2Cleared", {28'd0, result}, 32'd0);
        dealSix(4'd10, 4'd5, 4'd6, 4'd1, 4'd9, 4'd10);
        waitSeat(2'd1, "r2Seat1");
        checkOutput("r2Sums",   {20'd0, seatSum}, 32'd917);    // s1=14, s0=21
        checkOutput("r2Dealer", {26'd0, dealerSum}, 32'd16);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("r2NextSeat", {29'd0, state}, {29'd0, S_NEXT_SEAT});
        waitState(S_DEALER, "r2Dealer");
        feedCard(4'd10);
        checkOutput("r2DealerBust", {26'd0, dealerSum}, 32'd26);
        waitState(S_DONE, "r2DoneSt");
        checkOutput("r2Result", {28'd0, result}, 32'b1111);
        checkOutput("r2Pulse",  {31'd0, roundDone}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("r2StartIgnored", {29'd0, state}, {29'd0, S_IDLE});

        // ---- round 3: hit+stand same cycle, junk rank, dealer to 21 ----
        applyStimulus(1'b1, 1'b0, 1'b0);
        dealSix(4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7);
        waitSeat(2'd0, "r3Seat0");
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("r3HitStandSt",  {29'd0, state}, {29'd0, S_NEXT_SEAT});
        checkOutput("r3HitStandReq", {31'd0, cardReq}, 32'd0);
        checkOutput("r3S0Sum",       {26'd0, seatSum[5:0]}, 32'd7);
        waitSeat(2'd1, "r3Seat1");
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("r3HitReq", {31'd0, cardReq}, 32'd1);
        cardValid = 1'b1;
        cardRank  = 4'd14;
        step();
        checkOutput("r3JunkReq", {31'd0, cardReq}, 32'd1);
        checkOutput("r3JunkSum", {26'd0, seatSum[11:6]}, 32'd9);
        cardRank = 4'd5;
        step();
        cardValid = 1'b0;
        cardRank  = 4'd0;
        checkOutput("r3TakeSum", {26'd0, seatSum[11:6]}, 32'd14);
        checkOutput("r3TakeReq", {31'd0, cardReq}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("r3StandSt", {29'd0, state}, {29'd0, S_NEXT_SEAT});
        waitState(S_DEALER, "r3Dealer");
        feedCard(4'd10);
        waitState(S_DONE, "r3DoneSt");
        checkOutput("r3Dealer21", {26'd0, dealerSum}, 32'd21);
        checkOutput("r3Result",   {28'd0, result}, 32'b0101);
        step();

        // ---- round 4: dealer soft 17 (A,6) ----
        applyStimulus(1'b1, 1'b0, 1'b0);
        dealSix(4'd10, 4'd10, 4'd1, 4'd8, 4'd9, 4'd6);
        waitSeat(2'd0, "r4Seat0");
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitSeat(2'd1, "r4Seat1");
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitState(S_DEALER, "r4Dealer");
        checkOutput("r4Soft17",  {26'd0, dealerSum}, 32'd17);
        checkOutput("r4ReqLow",  {31'd0, cardReq}, 32'd0);
        step();
`ifdef DEALER_HIT_SOFT17_EN
        checkOutput("r4HitSoft", {31'd0, cardReq}, 32'd1);
        feedCard(4'd2);
        checkOutput("r4Dealer19", {26'd0, dealerSum}, 32'd19);
        waitState(S_DONE, "r4DoneSt");
        checkOutput("r4Result", {28'd0, result}, 32'b1001);
`else
        checkOutput("r4StandSt", {29'd0, state}, {29'd0, S_SETTLE});
        checkOutput("r4NoReq",   {31'd0, cardReq}, 32'd0);
        step();
        checkOutput("r4DoneSt", {29'd0, state}, {29'd0, S_DONE});
        checkOutput("r4Result", {28'd0, result}, 32'b1111);
`endif
        step();

        // ---- round 5: reset while the dealer has a request pending ----
        applyStimulus(1'b1, 1'b0, 1'b0);
        dealSix(4'd10, 4'd10, 4'd2, 4'd10, 4'd10, 4'd3);
        waitSeat(2'd0, "r5Seat0");
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitSeat(2'd1, "r5Seat1");
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitState(S_DEALER, "r5Dealer");
        n = 0;
        while (cardReq !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checkOutput("r5DealerReq", {31'd0, cardReq}, 32'd1);
        reset     = 1'b1;
        cardValid = 1'b1;
        cardRank  = 4'd10;
        step();
        reset     = 1'b0;
        cardValid = 1'b0;
        cardRank  = 4'd0;
        checkOutput("r5RstState",  {29'd0, state}, 32'd0);
        checkOutput("r5RstReq",    {31'd0, cardReq}, 32'd0);
        checkOutput("r5RstSums",   {20'd0, seatSum}, 32'd0);
        checkOutput("r5RstDealer", {26'd0, dealerSum}, 32'd0);
        checkOutput("r5RstResult", {28'd0, result}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
